// File: rtl/rf_arbiter_if.sv
// Bus bundle between the two requesting masters, the arbiter and the register file.
// The slave modport is the arbiter's view; the master modport is its environment.
interface rf_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              m0_req_i;
    logic              m0_we_i;
    logic [ADDR_W-1:0] m0_addr_i;
    logic [DATA_W-1:0] m0_data_i;
    logic [DATA_W-1:0] m0_data_o;
    logic              m0_done_o;
    logic              m0_err_o;

    logic              m1_req_i;
    logic              m1_we_i;
    logic [ADDR_W-1:0] m1_addr_i;
    logic [DATA_W-1:0] m1_data_i;
    logic [DATA_W-1:0] m1_data_o;
    logic              m1_done_o;
    logic              m1_err_o;

    logic [ADDR_W-1:0] rf_addr_o;
    logic [DATA_W-1:0] rf_data_o;
    logic [DATA_W-1:0] rf_data_i;
    logic              rf_we_o;
    logic              rf_re_o;
    logic              rf_ack_i;

    modport slave (
        input  m0_req_i, m0_we_i, m0_addr_i, m0_data_i,
        output m0_data_o, m0_done_o, m0_err_o,
        input  m1_req_i, m1_we_i, m1_addr_i, m1_data_i,
        output m1_data_o, m1_done_o, m1_err_o,
        output rf_addr_o, rf_data_o, rf_we_o, rf_re_o,
        input  rf_data_i, rf_ack_i
    );

    modport master (
        output m0_req_i, m0_we_i, m0_addr_i, m0_data_i,
        input  m0_data_o, m0_done_o, m0_err_o,
        output m1_req_i, m1_we_i, m1_addr_i, m1_data_i,
        input  m1_data_o, m1_done_o, m1_err_o,
        input  rf_addr_o, rf_data_o, rf_we_o, rf_re_o,
        output rf_data_i, rf_ack_i
    );
endinterface

// File: rtl/rf_arbiter.sv
// Two-master round-robin arbiter in front of a register file, with a per-access
// acknowledge timeout that completes the transaction with an error flag.
module rf_arbiter #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int TMO_CYC = 15
) (
    input  logic         sys_clk_i,
    input  logic         sys_rst_i,
    rf_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic              ptr;
    logic              grant;
    logic              grant_nxt;
    logic              grant_vld;
    logic              lat_we;
    logic              err_q;
    logic              timeout;
    logic [7:0]        tmo_cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] m0_rdata;
    logic [DATA_W-1:0] m1_rdata;

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) state <= IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        // NOTE: every signal written here is defaulted first, so no path can infer a latch.
        state_nxt = state;
        grant_vld = 1'b0;
        grant_nxt = ptr;
        // Fires on the TMO_CYC-th consecutive unacknowledged ACCESS cycle.
        timeout   = (tmo_cnt == 8'(TMO_CYC - 1));
        unique case (state)
            IDLE: begin
                grant_vld = bus.m0_req_i | bus.m1_req_i;
                if (bus.m0_req_i && bus.m1_req_i) grant_nxt = ptr;
                else                              grant_nxt = bus.m1_req_i;
                if (grant_vld) state_nxt = ACCESS;
            end
            ACCESS:  if (bus.rf_ack_i || timeout) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (sys_rst_i) begin
            ptr      <= 1'b0;
            grant    <= 1'b0;
            lat_we   <= 1'b0;
            err_q    <= 1'b0;
            tmo_cnt  <= 8'd0;
            addr_q   <= '0;
            wdata_q  <= '0;
            m0_rdata <= '0;
            m1_rdata <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (grant_vld) begin
                        grant   <= grant_nxt;
                        lat_we  <= grant_nxt ? bus.m1_we_i   : bus.m0_we_i;
                        addr_q  <= grant_nxt ? bus.m1_addr_i : bus.m0_addr_i;
                        wdata_q <= grant_nxt ? bus.m1_data_i : bus.m0_data_i;
                        tmo_cnt <= 8'd0;
                    end
                end
                ACCESS: begin
                    if (bus.rf_ack_i) begin
                        err_q <= 1'b0;
                        if (!lat_we) begin
                            if (grant) m1_rdata <= bus.rf_data_i;
                            else       m0_rdata <= bus.rf_data_i;
                        end
                    end else if (timeout) begin
                        err_q <= 1'b1;
                        if (grant) m1_rdata <= '0;
                        else       m0_rdata <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                // Hand priority to the master that just lost, error or not.
                RESP:    ptr <= ~grant;
                default: ;
            endcase
        end
    end

    assign bus.rf_we_o   = (state == ACCESS) &&  lat_we;
    assign bus.rf_re_o   = (state == ACCESS) && !lat_we;
    assign bus.rf_addr_o = addr_q;
    assign bus.rf_data_o = wdata_q;

    assign bus.m0_done_o = (state == RESP) && !grant;
    assign bus.m1_done_o = (state == RESP) &&  grant;
    assign bus.m0_err_o  = (state == RESP) && !grant && err_q;
    assign bus.m1_err_o  = (state == RESP) &&  grant && err_q;
    assign bus.m0_data_o = m0_rdata;
    assign bus.m1_data_o = m1_rdata;
endmodule

// File: tb/tb_rf_arbiter.sv
// Self-checking bench for rf_arbiter: directed vector table, randomized transactions
// against a transaction-level model, and hand-written reset / round-robin sequences.
module tb_rf_arbiter;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;
    localparam int TMO    = 15;

    typedef struct {
        logic        req0;
        logic        we0;
        logic [7:0]  addr0;
        logic [31:0] wd0;
        logic        req1;
        logic        we1;
        logic [7:0]  addr1;
        logic [31:0] wd1;
        int          lat;        // ACCESS cycles before the register file acks
        logic [31:0] rdval;
        int          exp_grant;
        int          exp_cyc;    // number of ACCESS cycles
        logic        exp_err;
        logic [31:0] exp_data;   // granted master's data_o after completion
    } vec_t;

    typedef struct {
        bit          v;
        logic        we;
        logic [7:0]  a;
        logic [31:0] d;
    } pend_t;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;
    int   shadow_ptr;
    logic [31:0] shadow_data [2];

    rf_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    rf_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TMO_CYC(TMO)) dut (
        .sys_clk_i (clk),
        .sys_rst_i (rst),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at %0t, required to have finished", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check_b(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, required %b", name, act, exp);
        end
    endtask

    task automatic check_w(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        bus.m0_req_i = 1'b0;
        bus.m1_req_i = 1'b0;
        bus.rf_ack_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_w("rst m0_data", bus.m0_data_o, 32'h0);
        check_w("rst m1_data", bus.m1_data_o, 32'h0);
        check_b("rst m0_done", bus.m0_done_o, 1'b0);
        check_b("rst m1_done", bus.m1_done_o, 1'b0);
        check_b("rst m0_err",  bus.m0_err_o,  1'b0);
        check_b("rst m1_err",  bus.m1_err_o,  1'b0);
        check_w("rst rf_addr", 32'(bus.rf_addr_o), 32'h0);
        check_w("rst rf_data", bus.rf_data_o, 32'h0);
        check_b("rst rf_we",   bus.rf_we_o,   1'b0);
        check_b("rst rf_re",   bus.rf_re_o,   1'b0);
        rst = 1'b0;
        shadow_ptr     = 0;
        shadow_data[0] = 32'h0;
        shadow_data[1] = 32'h0;
    endtask

    // Starts and ends at #1 after a rising edge with the arbiter in IDLE.
    task automatic run_vec(input vec_t v, input string tag);
        int          g;
        logic        we;
        logic [7:0]  a;
        logic [31:0] d;
        g  = v.exp_grant;
        we = (g == 1) ? v.we1   : v.we0;
        a  = (g == 1) ? v.addr1 : v.addr0;
        d  = (g == 1) ? v.wd1   : v.wd0;
        bus.m0_req_i = v.req0; bus.m0_we_i = v.we0; bus.m0_addr_i = v.addr0; bus.m0_data_i = v.wd0;
        bus.m1_req_i = v.req1; bus.m1_we_i = v.we1; bus.m1_addr_i = v.addr1; bus.m1_data_i = v.wd1;
        bus.rf_ack_i  = 1'b0;
        bus.rf_data_i = v.rdval;
        check_b({tag, " idle strobe"}, bus.rf_we_o | bus.rf_re_o, 1'b0);
        @(posedge clk); #1;
        // The granted master withdraws and scrambles its inputs; the access must not notice.
        if (g == 1) begin
            bus.m1_req_i = 1'b0; bus.m1_we_i = ~v.we1; bus.m1_addr_i = ~v.addr1; bus.m1_data_i = ~v.wd1;
        end else begin
            bus.m0_req_i = 1'b0; bus.m0_we_i = ~v.we0; bus.m0_addr_i = ~v.addr0; bus.m0_data_i = ~v.wd0;
        end
        for (int k = 0; k < v.exp_cyc; k++) begin
            check_b($sformatf("%s acc%0d rf_we", tag, k), bus.rf_we_o, we);
            check_b($sformatf("%s acc%0d rf_re", tag, k), bus.rf_re_o, ~we);
            check_w($sformatf("%s acc%0d rf_addr", tag, k), 32'(bus.rf_addr_o), 32'(a));
            check_w($sformatf("%s acc%0d rf_data", tag, k), bus.rf_data_o, d);
            check_b($sformatf("%s acc%0d done", tag, k), bus.m0_done_o | bus.m1_done_o, 1'b0);
            bus.rf_ack_i = (k >= v.lat);
            @(posedge clk); #1;
        end
        bus.rf_ack_i = 1'b0;
        shadow_data[g] = v.exp_data;
        shadow_ptr     = 1 - g;
        check_b({tag, " m0_done"}, bus.m0_done_o, g == 0);
        check_b({tag, " m1_done"}, bus.m1_done_o, g == 1);
        check_b({tag, " m0_err"},  bus.m0_err_o,  (g == 0) && v.exp_err);
        check_b({tag, " m1_err"},  bus.m1_err_o,  (g == 1) && v.exp_err);
        check_b({tag, " resp strobe"}, bus.rf_we_o | bus.rf_re_o, 1'b0);
        check_w({tag, " m0_data"}, bus.m0_data_o, shadow_data[0]);
        check_w({tag, " m1_data"}, bus.m1_data_o, shadow_data[1]);
        @(posedge clk); #1;
        check_b({tag, " done cleared"}, bus.m0_done_o | bus.m1_done_o, 1'b0);
    endtask

    vec_t  tbl [9];
    vec_t  rv;
    pend_t pend [2];
    int    order [$];

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        bus.m0_req_i = 1'b0; bus.m0_we_i = 1'b0; bus.m0_addr_i = '0; bus.m0_data_i = '0;
        bus.m1_req_i = 1'b0; bus.m1_we_i = 1'b0; bus.m1_addr_i = '0; bus.m1_data_i = '0;
        bus.rf_ack_i = 1'b0; bus.rf_data_i = '0;

        //          req we  addr   wdata          req we  addr   wdata          lat rdval          g  cyc err   data
        tbl[0] = '{1'b1,1'b1,8'h01,32'd100,      1'b0,1'b0,8'h00,32'h0,        0,  32'h0,         0, 1,  1'b0, 32'h0};
        tbl[1] = '{1'b0,1'b0,8'h00,32'h0,        1'b1,1'b0,8'h02,32'h0,        0,  32'h55,        1, 1,  1'b0, 32'h55};
        tbl[2] = '{1'b1,1'b1,8'h10,32'hA5A5,     1'b1,1'b0,8'h20,32'h0,        1,  32'h77,        0, 2,  1'b0, 32'h0};
        tbl[3] = '{1'b1,1'b0,8'h11,32'h0,        1'b1,1'b0,8'h21,32'h0,        2,  32'h1234,      1, 3,  1'b0, 32'h1234};
        tbl[4] = '{1'b1,1'b0,8'h30,32'h0,        1'b0,1'b0,8'h00,32'h0,        3,  32'hDEAD,      0, 4,  1'b0, 32'hDEAD};
        tbl[5] = '{1'b0,1'b0,8'h00,32'h0,        1'b1,1'b1,8'h40,32'd7,        14, 32'h0,         1, 15, 1'b0, 32'h1234};
        tbl[6] = '{1'b1,1'b0,8'hFF,32'h0,        1'b0,1'b0,8'h00,32'h0,        255,32'hBEEF,      0, 15, 1'b1, 32'h0};
        tbl[7] = '{1'b0,1'b0,8'h00,32'h0,        1'b1,1'b0,8'h41,32'h0,        15, 32'hCAFE,      1, 15, 1'b1, 32'h0};
        tbl[8] = '{1'b1,1'b1,8'h02,32'd3,        1'b1,1'b1,8'h03,32'd4,        0,  32'h0,         0, 1,  1'b0, 32'h0};

        apply_reset();
        for (int i = 0; i < 9; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

        // Randomized transactions predicted by a transaction-level model.
        pend[0].v = 1'b0;
        pend[1].v = 1'b0;
        for (int t = 0; t < 60; t++) begin
            int g;
            for (int i = 0; i < 2; i++) begin
                if (!pend[i].v && $urandom_range(0, 99) < 70) begin
                    pend[i].v = 1'b1; pend[i].we = 1'($urandom_range(0, 1));
                    pend[i].a = 8'($urandom); pend[i].d = $urandom;
                end
            end
            if (!pend[0].v && !pend[1].v) begin
                g = int'($urandom_range(0, 1));
                pend[g].v = 1'b1; pend[g].we = 1'($urandom_range(0, 1));
                pend[g].a = 8'($urandom); pend[g].d = $urandom;
            end
            rv.req0 = pend[0].v; rv.we0 = pend[0].we; rv.addr0 = pend[0].a; rv.wd0 = pend[0].d;
            rv.req1 = pend[1].v; rv.we1 = pend[1].we; rv.addr1 = pend[1].a; rv.wd1 = pend[1].d;
            rv.lat   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, TMO + 3)) : int'($urandom_range(0, 2));
            rv.rdval = $urandom;
            g = (pend[0].v && pend[1].v) ? shadow_ptr : (pend[0].v ? 0 : 1);
            rv.exp_grant = g;
            rv.exp_err   = (rv.lat >= TMO);
            rv.exp_cyc   = rv.exp_err ? TMO : rv.lat + 1;
            rv.exp_data  = rv.exp_err ? 32'h0 : (pend[g].we ? shadow_data[g] : rv.rdval);
            pend[g].v = 1'b0;
            run_vec(rv, $sformatf("rnd%0d", t));
        end

        // Both masters request continuously from reset: completions must alternate m0, m1, m0, m1.
        apply_reset();
        bus.m0_req_i = 1'b1; bus.m0_we_i = 1'b0; bus.m0_addr_i = 8'h0A;
        bus.m1_req_i = 1'b1; bus.m1_we_i = 1'b0; bus.m1_addr_i = 8'h0B;
        bus.rf_ack_i = 1'b1; bus.rf_data_i = 32'h99;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            check_b($sformatf("rr cyc%0d both done", c), bus.m0_done_o & bus.m1_done_o, 1'b0);
            if (bus.m0_done_o) order.push_back(0);
            if (bus.m1_done_o) order.push_back(1);
        end
        check_w("rr done count", 32'(order.size()), 32'd4);
        for (int i = 0; i < order.size(); i++)
            check_w($sformatf("rr order%0d", i), 32'(order[i]), 32'(i % 2));
        bus.m0_req_i = 1'b0; bus.m1_req_i = 1'b0; bus.rf_ack_i = 1'b0;

        // Reset during the second ACCESS cycle of a pending read.
        apply_reset();
        tbl[0] = '{1'b1,1'b0,8'h07,32'h0, 1'b0,1'b0,8'h00,32'h0, 0, 32'hABC, 0, 1, 1'b0, 32'hABC};
        run_vec(tbl[0], "pre_rst");
        bus.m0_req_i = 1'b1; bus.m0_we_i = 1'b0; bus.m0_addr_i = 8'h05;
        bus.m1_req_i = 1'b1; bus.m1_we_i = 1'b0; bus.m1_addr_i = 8'h06;
        bus.rf_ack_i = 1'b0;
        @(posedge clk); #1;
        check_w("mid grant m1 addr", 32'(bus.rf_addr_o), 32'h06);
        @(posedge clk); #1;
        check_b("mid 2nd access re", bus.rf_re_o, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        check_b("mid rst rf_re", bus.rf_re_o, 1'b0);
        check_b("mid rst rf_we", bus.rf_we_o, 1'b0);
        check_b("mid rst done",  bus.m0_done_o | bus.m1_done_o, 1'b0);
        check_w("mid rst m0_data", bus.m0_data_o, 32'h0);
        check_w("mid rst rf_addr", 32'(bus.rf_addr_o), 32'h0);
        rst = 1'b0;
        bus.rf_ack_i = 1'b1; bus.rf_data_i = 32'h66;
        @(posedge clk); #1;
        check_w("post rst grant m0 addr", 32'(bus.rf_addr_o), 32'h05);
        check_b("post rst no done", bus.m0_done_o | bus.m1_done_o, 1'b0);
        @(posedge clk); #1;
        check_b("post rst m0_done", bus.m0_done_o, 1'b1);
        check_b("post rst m1_done", bus.m1_done_o, 1'b0);
        check_w("post rst m0_data", bus.m0_data_o, 32'h66);
        bus.m0_req_i = 1'b0; bus.m1_req_i = 1'b0; bus.rf_ack_i = 1'b0;
        @(posedge clk); #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/rf_arbiter.md
RF_ARBITER -- requirements
Module: rf_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8, register-file address width.
REQ-002 Parameter DATA_W, default 32, register-file data width.
REQ-003 Parameter TMO_CYC, default 15, max ACCESS cycles without ack before error; legal range 1..255.
REQ-004 sys_clk_i  in  1  system clock; all logic on rising edge.
REQ-005 sys_rst_i  in  1  reset, synchronous, active-high.
REQ-006 mN_req_i  in  1  master N (N=0,1) transaction request, level.
REQ-007 mN_we_i  in  1  master N direction: 1 write, 0 read.
REQ-008 mN_addr_i  in  ADDR_W  master N register address.
REQ-009 mN_data_i  in  DATA_W  master N write data.
REQ-010 mN_data_o  out  DATA_W  master N read data.
REQ-011 mN_done_o  out  1  master N completion pulse.
REQ-012 mN_err_o  out  1  master N timeout flag, valid with mN_done_o.
REQ-013 rf_addr_o  out  ADDR_W  address to register file.
REQ-014 rf_data_o  out  DATA_W  write data to register file.
REQ-015 rf_data_i  in  DATA_W  read data from register file.
REQ-016 rf_we_o / rf_re_o  out  1 each  write / read strobes to register file.
REQ-017 rf_ack_i  in  1  register-file acknowledge (combinational on address).

Function
REQ-018 FSM states SHALL be IDLE, ACCESS, RESP; reset state IDLE.
REQ-019 IDLE: no request -> stay; one master requesting -> grant it; both -> grant master indicated by priority pointer.
REQ-020 On grant, addr/we/data of granted master SHALL be latched into rf_addr_o/rf_data_o and grant index stored; next state ACCESS.
REQ-021 ACCESS: rf_we_o = latched we, rf_re_o = not latched we, both held for every ACCESS cycle; both 0 in all other states.
REQ-022 ACCESS with rf_ack_i=1: read -> capture rf_data_i into granted mN_data_o; next state RESP, err=0.
REQ-023 ACCESS with rf_ack_i=0: increment timeout counter; after TMO_CYC consecutive unacked ACCESS cycles -> RESP, err=1, granted mN_data_o loaded with 0.
REQ-024 Timeout counter SHALL clear on entry to ACCESS; width 8 bits, never wraps.
REQ-025 RESP: granted mN_done_o=1 (and mN_err_o per outcome) for exactly one cycle; other master's done/err stay 0; next state IDLE.
REQ-026 Priority pointer SHALL be set to the non-granted master on leaving RESP (round-robin), whether or not err.
REQ-027 Latency: req seen in IDLE at cycle T, ack in first ACCESS cycle -> strobe at T+1, done at T+2; minimum 3 cycles per transaction.
REQ-028 Masters SHALL hold req and inputs stable until done; arbiter ignores input changes after grant; dropping req mid-access does not abort.
REQ-029 req still high in IDLE after done is treated as a new transaction.
REQ-030 mN_data_o SHALL hold last completed read/timeout value for master N; writes do not modify it.
REQ-031 rf_addr_o/rf_data_o SHALL hold last latched values outside ACCESS.

Reset
REQ-032 Reset asserted in any state, including mid-ACCESS: next cycle state IDLE, pointer=0 (master 0 priority), counter=0.
REQ-033 Reset values: all mN_data_o, mN_done_o, mN_err_o, rf_addr_o, rf_data_o, rf_we_o, rf_re_o = 0.
REQ-034 Reset dominates all other inputs in the same cycle; aborted transaction gives no done.

Verification
REQ-035 m0 write addr 0x01 data 100 -> rf_we_o=1 one cycle, ack -> m0_done_o pulse 2 cycles after req, err=0.
REQ-036 m1 read addr 0x02, rf_data_i=0x55 -> rf_re_o=1 one cycle, m1_data_o=0x55 with m1_done_o.
REQ-037 m0 and m1 request same cycle after reset, held -> order m0, m1, m0, m1; each done one cycle, never both.
REQ-038 Read unmapped addr, rf_ack_i=0, TMO_CYC=15 -> 15 ACCESS cycles, then m0_done_o=1, m0_err_o=1, m0_data_o=0.
REQ-039 Reset on 2nd ACCESS cycle of pending read -> strobes 0 next cycle, no done, next request granted to m0 first.
